// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bundle between the processor memory port and mem_responder
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word RAM responder with programmable wait states, one response per request
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept, resp_load, rsp_done;

  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic          rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q;

  logic          use_we, use_err;
  logic [31:0]   use_addr, use_wdata;
  logic [ADDR_W-1:0] idx;

  logic [31:0]   ram [DEPTH];

  assign bus.req_ready = rst_n && (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // With zero wait states the access happens on the accept edge, so take the live request.
  always_comb begin
    use_we    = (state == S_IDLE) ? bus.req_we    : we_q;
    use_addr  = (state == S_IDLE) ? bus.req_addr  : addr_q;
    use_wdata = (state == S_IDLE) ? bus.req_wdata : wdata_q;
    use_err   = (use_addr[1:0] != 2'b00) || (use_addr[31:ADDR_W+2] != '0);
    idx       = use_addr[ADDR_W+1:2];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    resp_load = 1'b0;
    rsp_done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CW'(WAIT_CYCLES - 1);
          end else begin
            state_nxt = S_RESP;
            resp_load = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_RESP;
          resp_load = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = S_IDLE;
          rsp_done  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (resp_load) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= use_err;
        rsp_rdata_q <= (!use_we && !use_err) ? ram[idx] : '0;
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= '0;
      end
    end
  end

  // RAM is not reset; the rst_n guard keeps a request seen during reset from committing.
  always_ff @(posedge clk) begin
    if (rst_n && resp_load && use_we && !use_err)
      ram[idx] <= use_wdata;
  end

endmodule
